// File: rtl/frame_pkg.sv
// Shared types and constants for the nibble-stream frame link (frame_packer / frame_unpacker).
package frame_pkg;

    localparam int W      = 42;
    localparam int BEAT   = 4;
    localparam int NBEATS = (W + BEAT - 1) / BEAT;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int SH_W   = $clog2(W);

    typedef enum bit [3:0] {
        KIND_A = 4'd0,
        KIND_B = 4'd1,
        KIND_C = 4'd2
    } kind_e;

    typedef struct packed {
        kind_e        kind;
        bit [W-1:0]   data;
    } frame_t;

    function automatic bit kind_valid(bit [3:0] k);
        return (k == 4'd0) || (k == 4'd1) || (k == 4'd2);
    endfunction

endpackage

// File: rtl/frame_unpacker_if.sv
// Beat input and frame output handshakes of the frame unpacker.
interface frame_unpacker_if;
    import frame_pkg::*;

    bit            in_valid;
    bit            in_ready;
    bit [BEAT-1:0] in_beat;
    bit            out_valid;
    bit            out_ready;
    frame_t        out_frame;
    bit            out_bits [W];
    bit            err;

    modport master (
        output in_valid, in_beat, out_ready,
        input  in_ready, out_valid, out_frame, out_bits, err
    );

    modport slave (
        input  in_valid, in_beat, out_ready,
        output in_ready, out_valid, out_frame, out_bits, err
    );

endinterface

// File: rtl/frame_unpacker.sv
// Reassembles a header beat plus NBEATS data beats (LS beat first) into a frame_t.
//
// state  | meaning
// S_HDR  | waiting for the header beat carrying the kind
// S_DATA | collecting data beats into data_q
// S_HOLD | completed frame presented, waiting for out_ready
module frame_unpacker
    import frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    frame_unpacker_if.slave    bus
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             bad;
    kind_e            kind_q;
    logic [W-1:0]     data_q;
    logic             beat_fire;
    logic [SH_W-1:0]  shift;
    logic [W-1:0]     data_next;

    assign beat_fire = bus.in_valid && bus.in_ready;
    assign shift     = SH_W'(cnt) * SH_W'(BEAT);
    // Shifting into a W-bit vector drops the spare upper bits of the final beat.
    assign data_next = data_q | (W'(bus.in_beat) << shift);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_HDR;
            cnt           <= '0;
            bad           <= 1'b0;
            kind_q        <= KIND_A;
            data_q        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.out_frame <= '0;
            for (int i = 0; i < W; i++) bus.out_bits[i] <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            unique case (state)
                S_HDR: begin
                    if (beat_fire) begin
                        kind_q <= kind_e'(bus.in_beat);
                        bad    <= !kind_valid(bus.in_beat);
                        data_q <= '0;
                        cnt    <= '0;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat_fire) begin
                        data_q <= data_next;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (bad) begin
                                bus.err <= 1'b1;
                                state   <= S_HDR;
                            end else begin
                                bus.out_frame <= '{kind: kind_q, data: data_next};
                                for (int i = 0; i < W; i++) bus.out_bits[i] <= data_next[i];
                                bus.out_valid <= 1'b1;
                                bus.in_ready  <= 1'b0;
                                state         <= S_HOLD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= S_HDR;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= S_HDR;
                end
            endcase
        end
    end

endmodule
